// File: rtl/dma_peripheral_responder_if.sv
// DMA bus and local stream bundle for dma_peripheral_responder.
// slave = the responder device, master = controller/local-side environment.
interface dma_peripheral_responder_if #(
  parameter int unsigned DATA_W = 8
);
  logic              dreq;
  logic              dackN;
  logic              iorN;
  logic              iowN;
  logic [DATA_W-1:0] dbIn;
  logic [DATA_W-1:0] dbOut;
  logic              dbOe;
  logic              eopNIn;
  logic              eopDrv;
  logic [DATA_W-1:0] lclWdata;
  logic              lclWvalid;
  logic              lclWready;
  logic [DATA_W-1:0] lclRdata;
  logic              lclRvalid;
  logic              lclRready;

  modport slave (
    output dreq, dbOut, dbOe, eopDrv, lclWready, lclRdata, lclRvalid,
    input  dackN, iorN, iowN, dbIn, eopNIn, lclWdata, lclWvalid, lclRready
  );

  modport master (
    input  dreq, dbOut, dbOe, eopDrv, lclWready, lclRdata, lclRvalid,
    output dackN, iorN, iowN, dbIn, eopNIn, lclWdata, lclWvalid, lclRready
  );
endinterface

// File: rtl/dma_peripheral_responder.sv
// Peripheral-side responder for an 8237 DMA controller with a local FIFO.
// Optional macro DMA_RESP_DEMAND_EN selects demand mode (DREQ held across back-to-back strobes).
module dma_peripheral_responder #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             dir,
  input  logic [CNT_W-1:0] blockLen,
  output logic             busy,
  output logic             done,
  output logic             err,
  dma_peripheral_responder_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  typedef enum logic [2:0] {IDLE, REQ, XFER, WAITREL, FIN} stateT;

  stateT             state, stateNext;
  logic              iorS, iorP, iowS, iowP, dackS, dackP, eopS;
  logic              dirQ, dreqQ, eopDrvQ, eopSeen;
  logic [CNT_W-1:0]  remaining;
  logic [DATA_W-1:0] dbLatch;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wrPtr, rdPtr;
  logic [LW-1:0]     level, levelNext;

  logic startAcc, granted, strobeS, strobeP, svc, lastWord, endBlock, dackRise;
  logic empty, full, ready, pushLcl, popLcl, pushBus, popBus, push, pop;

  // Bus pins are sampled once; edges are found against the previous sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iorS  <= 1'b1;
      iorP  <= 1'b1;
      iowS  <= 1'b1;
      iowP  <= 1'b1;
      dackS <= 1'b1;
      dackP <= 1'b1;
      eopS  <= 1'b1;
    end else begin
      iorS  <= bus.iorN;
      iorP  <= iorS;
      iowS  <= bus.iowN;
      iowP  <= iowS;
      dackS <= bus.dackN;
      dackP <= dackS;
      eopS  <= bus.eopNIn;
    end
  end

  assign startAcc = start && !busy;
  // WAITREL still owns the bus while DACK is low: a block-mode controller keeps strobing.
  assign granted  = (state == XFER) || (state == WAITREL);
  assign strobeS  = dirQ ? iowS : iorS;
  assign strobeP  = dirQ ? iowP : iorP;
  assign svc      = granted && strobeS && !strobeP;
  assign lastWord = (remaining == CNT_W'(1));
  assign endBlock = lastWord || eopSeen || !eopS;
  assign dackRise = dackS && !dackP;

  assign empty    = (level == '0);
  assign full     = (level == LW'(DEPTH));
  assign ready    = dirQ ? !full : !empty;
  assign pushLcl  = bus.lclWvalid && bus.lclWready;
  assign popLcl   = bus.lclRvalid && bus.lclRready;
  assign pushBus  = svc && dirQ && !full;
  assign popBus   = svc && !dirQ && !empty;
  assign push     = pushLcl || pushBus;
  assign pop      = popBus || popLcl;

  always_comb begin
    levelNext = level;
    if (push && !pop)      levelNext = level + LW'(1);
    else if (pop && !push) levelNext = level - LW'(1);
  end

`ifdef DMA_RESP_DEMAND_EN
  logic readyNext;
  assign readyNext = dirQ ? (levelNext != LW'(DEPTH)) : (levelNext != '0);
`endif

  // Next-state decode.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (busy && ready) stateNext = REQ;
      REQ:     if (!dackS) stateNext = XFER;
      XFER: begin
        if (svc) begin
          if (endBlock) stateNext = FIN;
`ifdef DMA_RESP_DEMAND_EN
          else if (!readyNext) stateNext = WAITREL;
`else
          else stateNext = WAITREL;
`endif
        end else if (dackRise && strobeS) begin
          stateNext = REQ;
        end
      end
      WAITREL: begin
        if (svc) begin
          if (endBlock) stateNext = FIN;
        end else if (dackS) begin
          stateNext = IDLE;
        end
      end
      FIN:     stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      dirQ      <= 1'b0;
      remaining <= '0;
      dreqQ     <= 1'b0;
      eopDrvQ   <= 1'b0;
      eopSeen   <= 1'b0;
    end else begin
      state   <= stateNext;
      done    <= (stateNext == FIN);
      dreqQ   <= (stateNext == REQ) || (stateNext == XFER);
      eopDrvQ <= granted && lastWord && !strobeS && !dackS;
      eopSeen <= granted && ((stateNext == XFER) || (stateNext == WAITREL)) && (eopSeen || !eopS);
      if (startAcc) begin
        busy      <= 1'b1;
        dirQ      <= dir;
        remaining <= blockLen;
        err       <= 1'b0;
      end else begin
        if (stateNext == FIN) busy <= 1'b0;
        if (svc) remaining <= remaining - CNT_W'(1);
        if (svc && (dirQ ? full : empty)) err <= 1'b1;
      end
    end
  end

  // Write data is captured while IOW is still asserted, so a late rise sample is safe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          dbLatch <= '0;
    else if (!bus.iowN)  dbLatch <= bus.dbIn;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      level <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + AW'(1);
      if (pop)  rdPtr <= rdPtr + AW'(1);
      level <= levelNext;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wrPtr] <= dirQ ? dbLatch : bus.lclWdata;
  end

  assign bus.dreq      = dreqQ;
  assign bus.eopDrv    = eopDrvQ;
  assign bus.dbOe      = granted && !dirQ && !bus.dackN && !bus.iorN;
  assign bus.dbOut     = (bus.dbOe && !empty) ? mem[rdPtr] : '0;
  assign bus.lclWready = !full && !dirQ;
  assign bus.lclRvalid = !empty && dirQ;
  assign bus.lclRdata  = mem[rdPtr];
endmodule
